// File: rtl/lcd_reader_pkg.sv
// Shared constants and state encoding for the character-LCD read path.
// Pin-level constants match the display writer so both drive the same bus.
package lcd_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EHIGH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;
  localparam logic RW_WR   = 1'b0;
  localparam logic RW_RD   = 1'b1;
  localparam int   BF_BIT  = 7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// Request/response and LCD pin bundle for lcd_reader.
// The slave modport is the reader itself.
interface lcd_reader_if;
  logic       i_req;
  logic       i_rs;
  logic       i_poll;
  logic [7:0] i_lcd_data;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_rdata;
  logic       o_busy;
  logic [6:0] o_addr;
  logic       o_timeout;
  logic       o_bus_rel;
  logic       o_E;
  logic       o_RS;
  logic       o_RW;

  modport master (
    output i_req, i_rs, i_poll, i_lcd_data,
    input  o_ready, o_valid, o_rdata, o_busy, o_addr,
    input  o_timeout, o_bus_rel, o_E, o_RS, o_RW
  );

  modport slave (
    input  i_req, i_rs, i_poll, i_lcd_data,
    output o_ready, o_valid, o_rdata, o_busy, o_addr,
    output o_timeout, o_bus_rel, o_E, o_RS, o_RW
  );
endinterface

// File: rtl/phase_counter.sv
// Loadable down-counter that parks at zero and flags it.
module phase_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/register.sv
// Enabled register with synchronous active-high clear.
module register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read-cycle engine: one busy/address or data read per
// request, optionally re-polling the busy flag until it clears.
module lcd_reader
  import lcd_reader_pkg::*;
#(
  parameter int T_AS     = 1,
  parameter int T_EH     = 2,
  parameter int T_EL     = 2,
  parameter int POLL_MAX = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  lcd_reader_if.slave  bus
);

  localparam int PW = $clog2(max3(T_AS, T_EH, T_EL) + 1);
  localparam int CW = $clog2(POLL_MAX + 1);

  state_t          state;
  state_t          state_d;
  logic            pc_load;
  logic [PW-1:0]   pc_val;
  logic            pc_zero;
  logic            accept;
  logic            sample;
  logic            again;
  logic            done;
  logic            more;
  logic            poll_flag;
  logic [CW-1:0]   poll_cnt;
  logic            rs_q;
  logic            valid_q;
  logic            tmo_q;
  logic [7:0]      rdata;
  logic            e_c;
  logic            rw_c;
  logic            rel_c;
  logic            rdy_c;

  phase_counter #(.W(PW)) u_phase (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (pc_load),
    .load_val (pc_val),
    .zero     (pc_zero)
  );

  register #(.W(8)) u_rdata (
    .clk (i_clk),
    .rst (i_rst),
    .en  (sample),
    .d   (bus.i_lcd_data),
    .q   (rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Repeat only while BF is still set and the read budget remains.
  assign more = poll_flag & rdata[BF_BIT]
              & (poll_cnt < CW'(POLL_MAX - 1));

  always_comb begin
    state_d = state;
    pc_load = 1'b0;
    pc_val  = '0;
    accept  = 1'b0;
    sample  = 1'b0;
    again   = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.i_req) begin
          state_d = ST_SETUP;
          pc_load = 1'b1;
          pc_val  = PW'(T_AS - 1);
          accept  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (pc_zero) begin
          state_d = ST_EHIGH;
          pc_load = 1'b1;
          pc_val  = PW'(T_EH - 1);
        end
      end
      ST_EHIGH: begin
        if (pc_zero) begin
          state_d = ST_HOLD;
          pc_load = 1'b1;
          pc_val  = PW'(T_EL - 1);
          sample  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (pc_zero) begin
          if (more) begin
            state_d = ST_SETUP;
            pc_load = 1'b1;
            pc_val  = PW'(T_AS - 1);
            again   = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    e_c   = 1'b0;
    rw_c  = RW_WR;
    rel_c = 1'b0;
    rdy_c = 1'b0;
    unique case (state)
      ST_IDLE:  rdy_c = 1'b1;
      ST_EHIGH: begin
        e_c   = 1'b1;
        rw_c  = RW_RD;
        rel_c = 1'b1;
      end
      ST_SETUP, ST_HOLD: begin
        rw_c  = RW_RD;
        rel_c = 1'b1;
      end
      default: rdy_c = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rs_q      <= RS_CMD;
      poll_flag <= 1'b0;
      poll_cnt  <= '0;
      valid_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      valid_q <= done;
      if (accept) begin
        rs_q      <= bus.i_rs;
        poll_flag <= bus.i_poll & ~bus.i_rs;
        poll_cnt  <= '0;
      end
      if (again) poll_cnt <= poll_cnt + 1'b1;
      if (done)  tmo_q <= poll_flag & rdata[BF_BIT];
    end
  end

  assign bus.o_ready   = rdy_c;
  assign bus.o_valid   = valid_q;
  assign bus.o_rdata   = rdata;
  assign bus.o_busy    = rdata[BF_BIT];
  assign bus.o_addr    = rdata[6:0];
  assign bus.o_timeout = tmo_q;
  assign bus.o_bus_rel = rel_c;
  assign bus.o_E       = e_c;
  assign bus.o_RS      = rs_q;
  assign bus.o_RW      = rw_c;

endmodule

// File: doc/lcd_reader.md
# lcd_reader

Read-side counterpart of the character-LCD write path. It runs HD44780-style read cycles (RW=1) to fetch either the busy flag and address counter (RS=0) or a DDRAM/CGRAM data byte (RS=1). It can optionally poll the busy flag until it clears, so command sequencers no longer rely on fixed delays. It sits beside the display writer on the same E/RS/RW/data pins; an external mux selects which block owns the bus.

## Interface
Parameters:
- T_AS, default 1: setup cycles with RS/RW valid before E rises (≥1).
- T_EH, default 2: E-high cycles (≥1).
- T_EL, default 2: hold cycles after E falls, with RW still 1 (≥1).
- POLL_MAX, default 16: maximum busy-flag reads per polled request (≥1).

Ports:
- i_clk, in, 1: clock, 25 kHz domain as the writer.
- i_rst, in, 1: one clock; reset is synchronous and active-high.
- i_req, in, 1: start a read; accepted when o_ready=1.
- i_rs, in, 1: 0 = busy flag/address, 1 = data.
- i_poll, in, 1: repeat busy reads until BF=0; ignored when i_rs=1.
- i_lcd_data, in, 8: LCD data bus input.
- o_ready, out, 1: idle, can accept i_req.
- o_valid, out, 1: one-cycle pulse, result available.
- o_rdata, out, 8: last sampled byte, held until the next sample.
- o_busy, out, 1: o_rdata[7].
- o_addr, out, 7: o_rdata[6:0].
- o_timeout, out, 1: qualifies o_valid; polling exhausted with BF still 1.
- o_bus_rel, out, 1: 1 = FPGA tristates its data drivers.
- o_E, out, 1: LCD enable.
- o_RS, out, 1: LCD register select.
- o_RW, out, 1: LCD read/write.

## Operation
- FSM states: IDLE → SETUP → EHIGH → HOLD → IDLE. A shared phase counter loads T_AS−1, T_EH−1 or T_EL−1 on state entry and advances at zero.
- IDLE: o_ready=1. On i_req, capture i_rs into o_RS, capture i_poll&~i_rs into a poll flag, clear the poll counter, and go to SETUP.
- SETUP: o_RW=1, o_bus_rel=1, o_E=0.
- EHIGH: o_E=1. At the final EHIGH edge, register i_lcd_data into o_rdata and drop E.
- HOLD: o_E=0; o_RW and o_bus_rel stay 1. At the end of HOLD:
  - If the poll flag is set, o_rdata[7]=1, and poll count < POLL_MAX−1: increment the count and go to SETUP (no o_valid).
  - Otherwise go to IDLE and pulse o_valid. o_timeout=1 only if polling ended with BF=1.
- On return to IDLE: o_RW=0, o_bus_rel=0. o_RS holds its value.
- The poll counter is $clog2(POLL_MAX+1) bits wide and never wraps.
- i_req is ignored while o_ready=0.

## Timing
- Reset values: o_ready=1, o_valid=0, o_rdata=0, o_timeout=0, o_bus_rel=0, o_E=0, o_RS=0, o_RW=0.
- For a request accepted at edge N, with S = T_AS+T_EH+T_EL:
  - SETUP occupies cycles N+1 .. N+T_AS.
  - E is high for cycles N+T_AS+1 .. N+T_AS+T_EH.
  - Data is sampled at the edge ending cycle N+T_AS+T_EH.
  - o_valid and o_ready are both 1 in cycle N+S+1. With defaults, accept at edge 0 gives valid in cycle 6.
- i_req asserted in the o_valid cycle is accepted (back-to-back). The one-cycle RW=0 gap is intentional.
- A polled request with k reads (k ≤ POLL_MAX) gives o_valid in cycle N+k·S+1. The SETUP of each repeat reuses T_AS.
- o_rdata and o_timeout change only at sample / o_valid; both are stable while o_ready=1.
- i_rst mid-cycle: at the next edge every output returns to its reset value. E drops immediately, no o_valid is emitted, and the partial sample is discarded (o_rdata=0).
- i_rst and i_req in the same cycle: reset wins and the request is dropped.

## Structure
- Shared package/include holds:
  - FSM state encodings.
  - Named constants RS_CMD=0, RS_DATA=1, RW_WR=0, RW_RD=1 and BF_BIT=7, shared with the display writer.
- Sub-module `phase_counter`: loadable down-counter with zero flag, parameterized width.
- The output byte uses the existing `register` module. Bus arbitration stays outside this block.

## Test plan
- Single busy read, defaults, i_lcd_data=8'h45 during E-high → o_valid in cycle 6, o_busy=0, o_addr=7'h45, o_timeout=0; E high exactly cycles 2–3; RW=1 cycles 1–5.
- Data read, i_rs=1, i_poll=1, bus=8'hA7 → single read (poll ignored), o_RS=1 throughout, o_rdata=8'hA7, valid at cycle 6.
- Polled read, BF=1 for three reads then bus=8'h12 → exactly 4 E pulses, o_valid at cycle 21, o_rdata=8'h12, o_timeout=0.
- Polled read, bus stuck at 8'h80, POLL_MAX=16 → 16 E pulses, then o_valid with o_timeout=1, o_rdata=8'h80.
- i_rst asserted during EHIGH → next edge o_E=0, o_RW=0, o_bus_rel=0, o_ready=1, o_rdata=0, no o_valid afterward.
- Back-to-back: i_req held high → valid at cycles 6, 12, 18; i_req pulsed while busy → ignored.
